rst_seq_wdog: RTL and testbench
===============================

RST_SEQ_WDOG -- requirements
Module: rst_seq_wdog

Interface
REQ-001 SHALL have parameter NCH, default 2, number of reset-output channels (1..8).
REQ-002 SHALL have parameter RST_CYCLES, default 2, clk cycles all channels are held in reset after synchronised release.
REQ-003 SHALL have parameter STAGGER, default 1, extra cycles between consecutive channel releases (0 = simultaneous).
REQ-004 SHALL have parameter MAX_CYCLES, default 100000, run-cycle watchdog limit.
REQ-005 SHALL have parameter CW, default 32, counter width; MAX_CYCLES < 2**CW.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port err  input  1  error flag, sampled on rising clk.
REQ-009 SHALL have port rst  output  NCH  per-channel active-high reset, bit i = channel i.
REQ-010 SHALL have port cycle_count  output  CW  run cycles elapsed.
REQ-011 SHALL have port err_seen  output  1  sticky, err captured in RUN.
REQ-012 SHALL have port err_cycle  output  CW  cycle_count value at err capture.
REQ-013 SHALL have port timeout  output  1  sticky, watchdog expired.
REQ-014 SHALL have port halt  output  1  err_seen | timeout, registered.

Function
REQ-015 SHALL implement states HOLD, RELEASE, RUN, HALT; encoding from package.
REQ-016 SHALL leave HOLD after RST_CYCLES cycles counted from the first edge with synchronised reset deasserted -> RELEASE.
REQ-017 SHALL deassert rst[i] at the edge ending RELEASE cycle i*STAGGER, lowest index first; RELEASE -> RUN on the edge deasserting rst[NCH-1].
REQ-018 SHALL increment cycle_count by 1 each edge in RUN only; frozen in HOLD, RELEASE, HALT.
REQ-019 SHALL, in RUN, on edge with err=1: set err_seen, load err_cycle with current (pre-increment) cycle_count, go HALT.
REQ-020 SHALL, in RUN, on edge where cycle_count == MAX_CYCLES-1: set timeout, go HALT; final cycle_count = MAX_CYCLES.
REQ-021 SHALL, on simultaneous err and watchdog expiry, set both err_seen and timeout and capture err_cycle.
REQ-022 SHALL ignore err in HOLD, RELEASE, HALT; err_seen/err_cycle never overwritten once set.
REQ-023 SHALL keep HALT until rst_n asserted; halt = 1 one edge after the capturing edge.

Reset
REQ-024 SHALL, while rst_n=0, immediately force rst to all-ones, state HOLD, cycle_count, err_cycle, err_seen, timeout, halt to 0.
REQ-025 SHALL synchronise rst_n deassertion through two flops; assertion is asynchronous.
REQ-026 SHALL restart the full sequence from HOLD on rst_n assertion in any state, including mid-RELEASE and HALT.

Configuration
REQ-027 SHALL honour macro RST_SEQ_HALT_RESET_EN: defined -> entering HALT re-asserts all rst bits on the same edge and keeps them asserted in HALT; undefined -> rst stays all-zero in HALT.

Structure
REQ-028 SHALL take state enum, default parameter constants and state width from shared package rst_seq_pkg.
REQ-029 SHALL instantiate sub-module rst_sync (two-flop async-assert/sync-deassert synchroniser, output active-low).

Verification
REQ-030 SHALL cover: NCH=3, RST_CYCLES=2, STAGGER=2, rst_n released at 201 -> rst = 111 for 2+sync cycles, then 110, 100, 000 two edges apart, RUN follows.
REQ-031 SHALL cover: err pulsed 1 cycle at cycle_count=37 -> err_seen=1, err_cycle=37, halt=1 next edge, cycle_count frozen at 37.
REQ-032 SHALL cover: MAX_CYCLES=50, err held 0 -> timeout=1, cycle_count=50, err_seen=0.
REQ-033 SHALL cover: MAX_CYCLES=50, err=1 exactly on edge with cycle_count=49 -> timeout=1, err_seen=1, err_cycle=49.
REQ-034 SHALL cover: rst_n low mid-RELEASE (rst=110) -> rst=111 without clk edge, all outputs 0, full sequence repeats.
REQ-035 SHALL cover: RST_SEQ_HALT_RESET_EN defined, err in RUN -> rst=all-ones on HALT entry; undefined -> rst stays 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared state encoding, default parameters and small helpers for the
// reset sequencer / run-cycle watchdog.
package rst_seq_pkg;

  localparam int STATE_W        = 2;
  localparam int DEF_NCH        = 2;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_STAGGER    = 1;
  localparam int DEF_MAX_CYCLES = 100000;
  localparam int DEF_CW         = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  function automatic logic halt_of(input logic err_seen, input logic timeout);
    return err_seen | timeout;
  endfunction

endpackage

// File: rtl/rst_seq_wdog_if.sv
// Connection between rst_seq_wdog and its user: the error flag in, the
// per-channel resets and watchdog status out.
interface rst_seq_wdog_if
  import rst_seq_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CW  = DEF_CW
);

  logic           err;
  logic [NCH-1:0] rst;
  logic [CW-1:0]  cycle_count;
  logic           err_seen;
  logic [CW-1:0]  err_cycle;
  logic           timeout;
  logic           halt;

  modport master (
    output err,
    input  rst, cycle_count, err_seen, err_cycle, timeout, halt
  );

  modport slave (
    input  err,
    output rst, cycle_count, err_seen, err_cycle, timeout, halt
  );

endinterface

// File: rtl/rst_seq_wdog_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the
// second clean clock edge. Output is active-low.
module rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic meta_r;
  logic sync_r;

  // Shift a constant one through two flops once reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= 1'b1;
      sync_r <= meta_r;
    end
  end

  assign rst_sync_n = sync_r;

endmodule

// File: rtl/rst_seq_wdog.sv
// Staggered reset sequencer with run-cycle watchdog and error capture.
// Optional macro RST_SEQ_HALT_RESET_EN re-asserts all resets while halted.
module rst_seq_wdog
  import rst_seq_pkg::*;
#(
  parameter int NCH        = DEF_NCH,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int STAGGER    = DEF_STAGGER,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int CW         = DEF_CW
) (
  input  logic           clk,
  input  logic           rst_n,
  rst_seq_wdog_if.slave  bus
);

  localparam logic [CW-1:0] HOLD_LAST = (RST_CYCLES > 0) ? CW'(RST_CYCLES - 1) : {CW{1'b0}};
  localparam logic [CW-1:0] REL_LAST  = CW'((NCH - 1) * STAGGER);
  localparam logic [CW-1:0] WDOG_LAST = CW'(MAX_CYCLES - 1);
`ifdef RST_SEQ_HALT_RESET_EN
  localparam logic [NCH-1:0] HALT_RST = {NCH{1'b1}};
`else
  localparam logic [NCH-1:0] HALT_RST = {NCH{1'b0}};
`endif

  state_e         state_r, state_nxt_s;
  logic           sync_n_s;
  logic           wdog_hit_s;
  logic [CW-1:0]  phase_cnt_r, phase_nxt_s;
  logic [CW-1:0]  cycle_r, cycle_nxt_s;
  logic [CW-1:0]  err_cycle_r, err_cycle_nxt_s;
  logic [NCH-1:0] rst_r, rst_nxt_s;
  logic           err_seen_r, err_seen_nxt_s;
  logic           timeout_r, timeout_nxt_s;
  logic           halt_r;

  rst_sync u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (sync_n_s)
  );

  assign wdog_hit_s = (cycle_r == WDOG_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_HOLD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath updates; phase_cnt_r is shared by HOLD and RELEASE
  always_comb begin
    state_nxt_s     = state_r;
    phase_nxt_s     = phase_cnt_r;
    cycle_nxt_s     = cycle_r;
    err_cycle_nxt_s = err_cycle_r;
    err_seen_nxt_s  = err_seen_r;
    timeout_nxt_s   = timeout_r;
    rst_nxt_s       = rst_r;
    case (state_r)
      ST_HOLD: begin
        rst_nxt_s = {NCH{1'b1}};
        if (sync_n_s) begin
          if (phase_cnt_r == HOLD_LAST) begin
            state_nxt_s = ST_RELEASE;
            phase_nxt_s = {CW{1'b0}};
          end else begin
            phase_nxt_s = phase_cnt_r + CW'(1);
          end
        end else begin
          phase_nxt_s = {CW{1'b0}};
        end
      end
      ST_RELEASE: begin
        for (int i = 0; i < NCH; i++) begin
          if (phase_cnt_r == CW'(i * STAGGER)) begin
            rst_nxt_s[i] = 1'b0;
          end else begin
            rst_nxt_s[i] = rst_r[i];
          end
        end
        if (phase_cnt_r == REL_LAST) begin
          state_nxt_s = ST_RUN;
          phase_nxt_s = {CW{1'b0}};
        end else begin
          phase_nxt_s = phase_cnt_r + CW'(1);
        end
      end
      ST_RUN: begin
        if (bus.err) begin
          err_seen_nxt_s  = 1'b1;
          err_cycle_nxt_s = cycle_r;
        end else begin
          err_seen_nxt_s  = err_seen_r;
          err_cycle_nxt_s = err_cycle_r;
        end
        if (wdog_hit_s) begin
          timeout_nxt_s = 1'b1;
        end else begin
          timeout_nxt_s = timeout_r;
        end
        // An error alone freezes the count; an expiring watchdog still completes it
        if (bus.err && !wdog_hit_s) begin
          cycle_nxt_s = cycle_r;
        end else begin
          cycle_nxt_s = cycle_r + CW'(1);
        end
        if (bus.err || wdog_hit_s) begin
          state_nxt_s = ST_HALT;
          rst_nxt_s   = HALT_RST;
        end else begin
          state_nxt_s = ST_RUN;
          rst_nxt_s   = {NCH{1'b0}};
        end
      end
      ST_HALT: begin
        rst_nxt_s = HALT_RST;
      end
      default: begin
        state_nxt_s = ST_HOLD;
        rst_nxt_s   = {NCH{1'b1}};
      end
    endcase
  end

  // Datapath registers; halt trails the sticky flags by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_r       <= {NCH{1'b1}};
      phase_cnt_r <= {CW{1'b0}};
      cycle_r     <= {CW{1'b0}};
      err_cycle_r <= {CW{1'b0}};
      err_seen_r  <= 1'b0;
      timeout_r   <= 1'b0;
      halt_r      <= 1'b0;
    end else begin
      rst_r       <= rst_nxt_s;
      phase_cnt_r <= phase_nxt_s;
      cycle_r     <= cycle_nxt_s;
      err_cycle_r <= err_cycle_nxt_s;
      err_seen_r  <= err_seen_nxt_s;
      timeout_r   <= timeout_nxt_s;
      halt_r      <= halt_of(err_seen_r, timeout_r);
    end
  end

  assign bus.rst         = rst_r;
  assign bus.cycle_count = cycle_r;
  assign bus.err_seen    = err_seen_r;
  assign bus.err_cycle   = err_cycle_r;
  assign bus.timeout     = timeout_r;
  assign bus.halt        = halt_r;

endmodule

// File: tb/tb_rst_seq_wdog.sv
// Randomised scoreboard bench for rst_seq_wdog (NCH=3, STAGGER=2, MAX_CYCLES=50).
module tb_rst_seq_wdog;

  localparam int NCH  = 3;
  localparam int RSTC = 2;
  localparam int STG  = 2;
  localparam int MAXC = 50;
  localparam int CW   = 16;
  localparam int MASK = (1 << NCH) - 1;
  // Edges after rst_n release: 2 sync edges, RSTC hold edges, then first release
  localparam int E0   = 2 + RSTC + 1;
  localparam int EL   = E0 + (NCH - 1) * STG;
`ifdef RST_SEQ_HALT_RESET_EN
  localparam int HALT_RST = MASK;
`else
  localparam int HALT_RST = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rst_seq_wdog_if #(.NCH(NCH), .CW(CW)) bus ();

  rst_seq_wdog #(
    .NCH(NCH), .RST_CYCLES(RSTC), .STAGGER(STG), .MAX_CYCLES(MAXC), .CW(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int edge_n; } rst_exp_t;
  typedef struct { int es; int ec; int to; int cc; bit chk_cc; int edge_n; } res_exp_t;

  rst_exp_t rst_q[$];
  res_exp_t res_q[$];
  int n_checks  = 0;
  int n_errors  = 0;
  int rel_edges = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic chk_reset_state(string tag);
    chk({tag, "_rst"}, int'(bus.rst), MASK);
    chk({tag, "_cycle_count"}, int'(bus.cycle_count), 0);
    chk({tag, "_err_seen"}, int'(bus.err_seen), 0);
    chk({tag, "_err_cycle"}, int'(bus.err_cycle), 0);
    chk({tag, "_timeout"}, int'(bus.timeout), 0);
    chk({tag, "_halt"}, int'(bus.halt), 0);
  endtask

  // One sequence: reset, release, optional err at cycle_count == c (c >= MAXC: none)
  task automatic run_trial(int c, int last_k_in);
    int err_edge, cap_edge, last_k;
    res_exp_t r;
    rst_exp_t e;
    err_edge = (c < MAXC) ? EL + c + 1 : -1;
    cap_edge = (c < MAXC) ? EL + c + 1 : EL + MAXC;
    last_k   = (last_k_in > 0) ? last_k_in : cap_edge + 4;

    rst_n    = 1'b0;
    bus.err  = 1'b0;
    #2;
    chk_reset_state("async_reset");
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < NCH; i++) begin
      e.edge_n = E0 + i * STG;
      e.val    = MASK & ~((1 << (i + 1)) - 1);
      if (e.edge_n <= last_k) rst_q.push_back(e);
    end
    if (HALT_RST != 0 && cap_edge <= last_k) begin
      e.edge_n = cap_edge;
      e.val    = HALT_RST;
      rst_q.push_back(e);
    end
    r.es     = (c < MAXC) ? 1 : 0;
    r.ec     = (c < MAXC) ? c : 0;
    r.to     = (c >= MAXC - 1) ? 1 : 0;
    r.cc     = (c < MAXC - 1) ? c : MAXC;
    r.chk_cc = (c != MAXC - 1);
    r.edge_n = cap_edge + 1;
    if (r.edge_n <= last_k) res_q.push_back(r);

    rst_n     = 1'b1;
    rel_edges = 0;
    for (int k = 1; k <= last_k; k++) begin
      if (k <= EL || k > cap_edge) bus.err = 1'($urandom_range(0, 1));
      else bus.err = (k == err_edge);
      @(posedge clk);
      rel_edges = k;
      @(negedge clk);
    end
    bus.err = 1'b0;

    if (last_k > cap_edge + 1) begin
      chk("halt_hold_err_seen", int'(bus.err_seen), r.es);
      chk("halt_hold_err_cycle", int'(bus.err_cycle), r.ec);
      chk("halt_hold_timeout", int'(bus.timeout), r.to);
      chk("halt_hold_halt", int'(bus.halt), 1);
      chk("halt_hold_rst", int'(bus.rst), HALT_RST);
      if (r.chk_cc) chk("halt_hold_cycle_count", int'(bus.cycle_count), r.cc);
    end
    chk("rst_q_drained", rst_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    rst_q.delete();
    res_q.delete();
  endtask

  // Monitor: pops an expectation whenever rst changes or halt rises
  initial begin
    int last_rst;
    bit halt_prev;
    rst_exp_t e;
    res_exp_t r;
    last_rst  = MASK;
    halt_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_rst  = MASK;
        halt_prev = 1'b0;
      end else begin
        if (int'(bus.rst) != last_rst) begin
          if (rst_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rst_unexpected: got %0d, expected %0d at edge %0d", bus.rst, last_rst, rel_edges);
          end else begin
            e = rst_q.pop_front();
            chk("rst_value", int'(bus.rst), e.val);
            chk("rst_edge", rel_edges, e.edge_n);
          end
          last_rst = int'(bus.rst);
        end
        if (bus.halt && !halt_prev) begin
          if (res_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL halt_unexpected: got 1, expected 0 at edge %0d", rel_edges);
          end else begin
            r = res_q.pop_front();
            chk("halt_edge", rel_edges, r.edge_n);
            chk("err_seen", int'(bus.err_seen), r.es);
            chk("err_cycle", int'(bus.err_cycle), r.ec);
            chk("timeout", int'(bus.timeout), r.to);
            if (r.chk_cc) chk("cycle_count", int'(bus.cycle_count), r.cc);
          end
        end
        halt_prev = bus.halt;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no finish, expected finish before 500000");
    $fatal(1, "bench time limit");
  end

  initial begin
    bus.err = 1'b0;
    @(negedge clk);
    run_trial(37, 0);
    run_trial(MAXC, 0);
    run_trial(MAXC - 1, 0);
    run_trial(20, E0 + 1);
    run_trial(0, 0);
    for (int t = 0; t < 7; t++) begin
      run_trial(int'($urandom_range(0, MAXC + 10)), 0);
    end
    rst_n = 1'b0;
    #2;
    chk_reset_state("final_reset");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
